// File: rtl/instruction_fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory and the decode stage.
// master = fetch stage, slave = surrounding pipeline/memory environment.
interface instruction_fetch_stage_if;
  logic        hazardDetected;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic        memReady;
  logic [31:0] memData;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] instructionID;
  logic [31:0] pcID;
  logic        validID;

  modport master (
    input  hazardDetected, branchTaken, branchAddress, memReady, memData,
    output memReq, memAddr, instructionID, pcID, validID
  );

  modport slave (
    output hazardDetected, branchTaken, branchAddress, memReady, memData,
    input  memReq, memAddr, instructionID, pcID, validID
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, memory request and the IF/ID pipeline register.
// Define IF_BUFFER_EN to add a one-entry buffer that keeps fetching across one stall cycle.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_stage_if.master bus
);

  typedef enum logic {FETCH, BUFFERED} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcId_q, pcId_d;
  logic        valid_q, valid_d;
  logic [31:0] pcPlus4;

`ifdef IF_BUFFER_EN
  logic [31:0] bufInstr_q, bufInstr_d;
  logic [31:0] bufPc_q, bufPc_d;
`endif

  assign pcPlus4 = pc_q + 32'd4;

  assign bus.memAddr       = pc_q;
  assign bus.instructionID = instr_q;
  assign bus.pcID          = pcId_q;
  assign bus.validID       = valid_q;
`ifdef IF_BUFFER_EN
  assign bus.memReq = (state_q == FETCH);
`else
  assign bus.memReq = !bus.hazardDetected;
`endif

  // Priority: branch flush, then stall, then accepting the memory response.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcId_d  = pcId_q;
    valid_d = valid_q;
`ifdef IF_BUFFER_EN
    bufInstr_d = bufInstr_q;
    bufPc_d    = bufPc_q;
`endif
    if (bus.branchTaken) begin
      pc_d    = bus.branchAddress;
      instr_d = 32'd0;
      pcId_d  = 32'd0;
      valid_d = 1'b0;
      state_d = FETCH;
    end else if (state_q == BUFFERED) begin
`ifdef IF_BUFFER_EN
      if (!bus.hazardDetected) begin
        instr_d = bufInstr_q;
        pcId_d  = bufPc_q;
        valid_d = 1'b1;
        state_d = FETCH;
      end
`else
      state_d = FETCH;
`endif
    end else if (bus.hazardDetected) begin
`ifdef IF_BUFFER_EN
      // The word arriving during the stall is parked rather than refetched.
      if (bus.memReady) begin
        bufInstr_d = bus.memData;
        bufPc_d    = pcPlus4;
        pc_d       = pcPlus4;
        state_d    = BUFFERED;
      end
`endif
    end else if (bus.memReady) begin
      instr_d = bus.memData;
      pcId_d  = pcPlus4;
      valid_d = 1'b1;
      pc_d    = pcPlus4;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcId_q  <= 32'd0;
      valid_q <= 1'b0;
`ifdef IF_BUFFER_EN
      bufInstr_q <= 32'd0;
      bufPc_q    <= 32'd0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcId_q  <= pcId_d;
      valid_q <= valid_d;
`ifdef IF_BUFFER_EN
      bufInstr_q <= bufInstr_d;
      bufPc_q    <= bufPc_d;
`endif
    end
  end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: hazardDetected  input  1  stall request from hazard detection; freezes PC and IF/ID register.
REQ-005 Port: branchTaken  input  1  branch resolved taken in EXE; redirects fetch and flushes IF/ID.
REQ-006 Port: branchAddress  input  32  branch target, sampled when branchTaken=1.
REQ-007 Port: memReady  input  1  instruction memory response valid for the current memAddr, same cycle.
REQ-008 Port: memData  input  32  instruction word, valid when memReady=1.
REQ-009 Port: memReq  output  1  fetch request; memAddr meaningful only when 1.
REQ-010 Port: memAddr  output  32  fetch address, equals PC register.
REQ-011 Port: instructionID  output  32  IF/ID register instruction.
REQ-012 Port: pcID  output  32  IF/ID register PC+4 of that instruction.
REQ-013 Port: validID  output  1  IF/ID register holds a real instruction; 0 = bubble.

Function
REQ-014 FSM shall have states FETCH and BUFFERED (BUFFERED reachable only with IF_BUFFER_EN).
REQ-015 In FETCH, memReq shall be 1 unless hazardDetected=1 without IF_BUFFER_EN; memAddr shall equal PC.
REQ-016 Priority each cycle: branchTaken > hazardDetected > memReady.
REQ-017 branchTaken=1 (any state): PC<=branchAddress, validID<=0, instructionID<=0, pcID<=0, buffer discarded, state<=FETCH, memData ignored that cycle.
REQ-018 FETCH, no branch, no hazard, memReady=1: instructionID<=memData, pcID<=PC+4, validID<=1, PC<=PC+4.
REQ-019 FETCH, no branch, no hazard, memReady=0: validID<=0 (bubble), instructionID/pcID hold, PC holds.
REQ-020 hazardDetected=1, no branch: instructionID, pcID, validID shall hold their values.
REQ-021 PC arithmetic shall be 32-bit modulo; PC+4 from 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 Fetch-to-ID latency shall be one cycle: word accepted at edge N is on instructionID after edge N.
REQ-023 No instruction shall be dropped or duplicated except those flushed by branchTaken.

Reset
REQ-024 rst=1 shall immediately set PC=RESET_PC, state=FETCH, validID=0, instructionID=0, pcID=0, buffer empty, independent of clk.
REQ-025 After rst deasserts, first memReq=1 with memAddr=RESET_PC shall appear in the same cycle (no extra idle cycle).
REQ-026 Reset mid-stall or while BUFFERED shall discard all held/buffered instructions.

Configuration
REQ-027 Macro IF_BUFFER_EN shall compile in a one-entry fetch buffer.
REQ-028 With IF_BUFFER_EN: in FETCH with hazardDetected=1 and memReady=1, memData and PC+4 shall be captured into the buffer, PC<=PC+4, state<=BUFFERED; memReq=0 in BUFFERED.
REQ-029 With IF_BUFFER_EN: in BUFFERED when hazardDetected=0 and no branch, IF/ID shall load buffer contents with validID=1, state<=FETCH.
REQ-030 Without IF_BUFFER_EN: memReq=0 while hazardDetected=1, PC held, no buffer storage exists.

Verification
REQ-031 Reset with RESET_PC=0, memReady tied 1, sequential words -> memAddr 0,4,8; pcID 4,8,12; validID=1 from first edge.
REQ-032 hazardDetected high 3 cycles mid-stream -> IF/ID unchanged for 3 cycles, resumes with next sequential instruction, none lost or duplicated.
REQ-033 branchTaken=1, branchAddress=32'h100, hazardDetected=1 same cycle -> validID=0 next cycle, memAddr=32'h100.
REQ-034 memReady=0 two cycles at PC=8 -> two bubbles (validID=0), memAddr stays 8.
REQ-035 IF_BUFFER_EN, hazard with memReady=1 at PC=8 -> BUFFERED, memReq=0; hazard clears -> instructionID=word@8, pcID=12, memAddr=12.
REQ-036 PC=32'hFFFF_FFFC, memReady=1 -> pcID=0, memAddr wraps to 0.
